// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite constants and FSM state types.
// Used by the register responder and its byte-lane merge helper.
package axil_pkg;

  localparam int AXIL_DATA_W   = 32;
  localparam int AXIL_STRB_W   = 4;
  localparam int AXIL_ADDR_LSB = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_e;

endpackage

// File: rtl/axil_reg_responder_if.sv
// axil_reg_responder_if: AXI4-Lite bus bundle.
// Slave modport for the responder, master modport for the driver.
interface axil_reg_responder_if #(
  parameter int ADDR_W = 32
);
  import axil_pkg::*;

  logic [ADDR_W-1:0]      S_AXI_AWADDR;
  logic [2:0]             S_AXI_AWPROT;
  logic                   S_AXI_AWVALID;
  logic                   S_AXI_AWREADY;
  logic [AXIL_DATA_W-1:0] S_AXI_WDATA;
  logic [AXIL_STRB_W-1:0] S_AXI_WSTRB;
  logic                   S_AXI_WVALID;
  logic                   S_AXI_WREADY;
  logic [1:0]             S_AXI_BRESP;
  logic                   S_AXI_BVALID;
  logic                   S_AXI_BREADY;
  logic [ADDR_W-1:0]      S_AXI_ARADDR;
  logic [2:0]             S_AXI_ARPROT;
  logic                   S_AXI_ARVALID;
  logic                   S_AXI_ARREADY;
  logic [AXIL_DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]             S_AXI_RRESP;
  logic                   S_AXI_RVALID;
  logic                   S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/axil_wstrb_merge.sv
// axil_wstrb_merge: byte-lane merge of old and new data.
// Lanes with strb set take new data; others keep old data.
module axil_wstrb_merge
  import axil_pkg::*;
(
  input  logic [AXIL_DATA_W-1:0] old_i,
  input  logic [AXIL_DATA_W-1:0] new_i,
  input  logic [AXIL_STRB_W-1:0] strb_i,
  output logic [AXIL_DATA_W-1:0] merged_o
);

  // Select each byte lane from new or old data
  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < AXIL_STRB_W; b++) begin
      if (strb_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/axil_reg_responder.sv
// axil_reg_responder: AXI4-Lite slave, NUM_REGS 32-bit registers.
// Define AXIL_REG_DECERR_EN to answer out-of-range addresses with SLVERR.
module axil_reg_responder
  import axil_pkg::*;
#(
  parameter int          NUM_REGS  = 4,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axil_reg_responder_if.slave      s_axi,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int HI    = AXIL_ADDR_LSB + IDX_W;

  typedef logic [AXIL_DATA_W-1:0] word_t;

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  wstate_e wst_q, wst_d;
  rstate_e rst_q, rst_d;

  logic awready_q, awready_d;
  logic wready_q, wready_d;
  logic bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
  word_t                  wdata_q, wdata_d;
  logic [AXIL_STRB_W-1:0] wstrb_q, wstrb_d;

  logic arready_q, arready_d;
  logic rvalid_q, rvalid_d;
  word_t rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic                   commit;
  logic [ADDR_W-1:0]      c_addr;
  word_t                  c_data;
  logic [AXIL_STRB_W-1:0] c_strb;
  logic [IDX_W-1:0]       c_idx;
  logic                   c_oor;
  word_t                  merged;

  logic [ADDR_W-1:0] ar_addr;
  logic [IDX_W-1:0]  ar_idx;
  logic              ar_oor;

  assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs  = s_axi.S_AXI_WVALID  & wready_q;
  assign b_hs  = bvalid_q & s_axi.S_AXI_BREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;
  assign r_hs  = rvalid_q & s_axi.S_AXI_RREADY;

  assign ar_addr = s_axi.S_AXI_ARADDR;
  assign ar_idx  = ar_addr[AXIL_ADDR_LSB +: IDX_W];
  assign c_idx   = c_addr[AXIL_ADDR_LSB +: IDX_W];

`ifdef AXIL_REG_DECERR_EN
  assign c_oor  = |c_addr[ADDR_W-1:HI];
  assign ar_oor = |ar_addr[ADDR_W-1:HI];
`else
  assign c_oor  = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Write FSM: collect AW and W in either order, then hold B
  always_comb begin
    wst_d    = wst_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    commit   = 1'b0;
    c_addr   = awaddr_q;
    c_data   = wdata_q;
    c_strb   = wstrb_q;
    unique case (wst_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_addr = s_axi.S_AXI_AWADDR;
          c_data = s_axi.S_AXI_WDATA;
          c_strb = s_axi.S_AXI_WSTRB;
        end else if (aw_hs) begin
          awaddr_d = s_axi.S_AXI_AWADDR;
          wst_d    = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d = s_axi.S_AXI_WDATA;
          wstrb_d = s_axi.S_AXI_WSTRB;
          wst_d   = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = s_axi.S_AXI_WDATA;
          c_strb = s_axi.S_AXI_WSTRB;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_addr = s_axi.S_AXI_AWADDR;
        end
      end
      W_RESP: begin
        if (b_hs) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
    if (commit) wst_d = W_RESP;
    awready_d = (wst_d == W_IDLE) || (wst_d == W_HAVE_W);
    wready_d  = (wst_d == W_IDLE) || (wst_d == W_HAVE_AW);
    bvalid_d  = (wst_d == W_RESP);
  end

  axil_wstrb_merge u_merge (
    .old_i   (regs_q[c_idx]),
    .new_i   (c_data),
    .strb_i  (c_strb),
    .merged_o(merged)
  );

  // Commit: update the addressed register, strobe and response code
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    bresp_d = bresp_q;
    if (commit) begin
      bresp_d = c_oor ? RESP_SLVERR : RESP_OKAY;
      if (!c_oor) begin
        regs_d[c_idx]  = merged;
        pulse_d[c_idx] = 1'b1;
      end
    end
  end

  // Read FSM: sample the register on AR, hold R until accepted
  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (rst_q)
      R_IDLE: begin
        if (ar_hs) begin
          rst_d   = R_RESP;
          rdata_d = ar_oor ? '0 : regs_q[ar_idx];
          rresp_d = ar_oor ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_RESP: begin
        if (r_hs) rst_d = R_IDLE;
      end
      default: rst_d = R_IDLE;
    endcase
    arready_d = (rst_d == R_IDLE);
    rvalid_d  = (rst_d == R_RESP);
  end

  // Write-path state and registered outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wst_q     <= wst_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Register file
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read-path state and registered outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rst_q     <= rst_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse        = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       c_addr, ar_addr};

endmodule

// File: doc/axil_reg_responder.md
Name: axil_reg_responder

Overview:
- AXI4-Lite slave (responder) exposing NUM_REGS 32-bit read/write control registers to fabric logic.
- Terminates transactions from the PS or the AXI4-Lite master BFM in the block-design bench.
- Independent write path (AW/W/B) and read path (AR/R), each a small FSM; register contents drive fabric outputs.
- Each committed write produces a one-cycle per-register strobe.

Parameters:
- NUM_REGS, 4, number of 32-bit registers; power of two, 2..64
- ADDR_W, 32, AXI address width
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_W  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  ADDR_W  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- reg_out  out  NUM_REGS*32  register contents; reg i at bits [32*i+31:32*i]
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe per committed register write

Behaviour:
- Reset values (cycle ARESET high):
  - all *READY, *VALID, RESP, RDATA, reg_wr_pulse = 0
  - all registers = RESET_VAL
  - both FSMs go to idle
- Readies rise in the first cycle after ARESET falls. All outputs are registered.
- Address decode:
  - index = addr[2 +: log2(NUM_REGS)]
  - addr[1:0] ignored
  - upper bits ignored, so the map aliases modulo 4*NUM_REGS (unless the macro below is defined)
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: AWREADY=WREADY=1.
    - AW and W both handshake in the same cycle → commit, go to W_RESP.
    - AW only → latch address, go to W_HAVE_AW (AWREADY=0, WREADY=1).
    - W only → latch data and strobe, go to W_HAVE_W (WREADY=0, AWREADY=1).
  - W_HAVE_AW / W_HAVE_W: the missing handshake commits the write, go to W_RESP.
  - Commit edge: bytes with WSTRB[b]=1 are replaced; the others keep their value. WSTRB=0 is legal: no change, pulse still fires.
  - After commit: reg_wr_pulse[index] is high exactly one cycle (the cycle after the commit edge); BVALID=1 in that same cycle.
  - W_RESP: AWREADY=WREADY=0; BVALID held with BRESP stable until BREADY. After the B handshake, readies are 1 in the next cycle.
  - Minimum throughput: one write per 2 cycles with BREADY tied high.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY=1. On AR handshake, latch RDATA from the indexed register; RVALID=1 in the next cycle; ARREADY=0.
  - R_RESP: RDATA/RRESP held until RREADY; ARREADY=1 the cycle after the R handshake.
  - Read latency is 1 cycle.
- Simultaneous read and write to the same register: the read samples at the write commit edge and returns the old value.
- BRESP/RRESP = OKAY (2'b00) always, unless the macro below is defined.
- ARESET asserted mid-transaction: pending AW/W/AR are dropped, no B/R is issued, registers go to RESET_VAL.

Optional Feature:
- Macro: AXIL_REG_DECERR_EN.
- Defined:
  - Any address bit at or above 2+log2(NUM_REGS) set → out of range.
  - Out-of-range write: no register change, no pulse, BRESP=SLVERR (2'b10).
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
  - Handshake timing unchanged.
- Undefined: addresses alias as described, all responses OKAY.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - AXIL_DATA_W=32, AXIL_STRB_W=4, AXIL_ADDR_LSB=2
  - enumerated typedefs for write and read FSM states
- Sub-module axil_wstrb_merge: combinational byte-lane merge of old data, new data and WSTRB. Reused by other register blocks.

Test Plan:
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read-back:
  - BRESP=RRESP=OKAY, data matches
  - reg_out slices equal the written values
  - reg_wr_pulse bits 0..3 fire once each
- AW at cycle 0, W at cycle 3 (and the reverse order): commit at the W/AW edge; BVALID exactly one cycle later; no commit before both arrive.
- Reg1=0xABCD0001, then write 0x11223344 with WSTRB=4'b0101 → reads 0xAB220044.
- Hold BREADY low 5 cycles after a write: BVALID/BRESP stable; AWREADY=WREADY=0 throughout; next write accepted the cycle after BREADY.
- Read reg2 at the same edge as a write of 0x5 to reg2 (old value 0xDEAD0011): RDATA=0xDEAD0011; a subsequent read returns 0x5.
- Assert ARESET while in W_HAVE_AW: no BVALID is issued, all registers read 0 afterward. With AXIL_REG_DECERR_EN defined, a write to 0x10 gives BRESP=SLVERR and a read of 0x10 gives RDATA=0, RRESP=SLVERR.
